bit_serializer: RTL and testbench

Parallel-to-serial front end for the bit-stream pattern detectors. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word ahead, and emits them one bit per enabled cycle as a registered serial bit with a per-bit valid strobe. The serial bit and strobe connect directly to a detector's serial input and valid input.

---
 rtl/bit_serializer.sv | 118 +++++++++++
 tb/tb_bit_serializer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over valid/ready, keeps one
// word prefetched in a hold register and emits one registered bit per enabled cycle.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] shr_q;
  logic [CW-1:0]    cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             word_done_q;

  logic             xfer;
  logic             last_bit;
  logic             emit_bit;
  logic [WIDTH-1:0] shr_shifted;

  // Handshake: a word moves on any edge where din_valid and din_ready are both
  // high; din_ready depends only on reset and the hold flag, never on din_valid.
  assign din_ready = rst & ~hold_full_q;
  assign xfer      = din_valid & din_ready;
  assign last_bit  = (cnt_q == LAST);
  assign busy      = (state_q == SHIFT) | hold_full_q;
  assign state_dbg = state_q;

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;

  // The shift register always moves toward the end that is emitted next.
  always_comb begin
    if (MSB_FIRST) begin
      emit_bit    = shr_q[WIDTH-1];
      shr_shifted = {shr_q[WIDTH-2:0], 1'b0};
    end else begin
      emit_bit    = shr_q[0];
      shr_shifted = {1'b0, shr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shr_q       <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;

      // Never coincides with a hold-to-shr reload: those need hold_full_q=1.
      if (xfer) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            shr_q       <= hold_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            ser_out_q   <= emit_bit;
            ser_valid_q <= 1'b1;
            shr_q       <= shr_shifted;
            cnt_q       <= cnt_q + CW'(1);
            if (last_bit) begin
              word_done_q <= 1'b1;
              cnt_q       <= '0;
              // A prefetched word reloads on the last bit so the stream has no gap.
              if (hold_full_q) begin
                shr_q       <= hold_q;
                hold_full_q <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed scenarios plus a randomized
// run scored against a word-level model of the expected serial stream.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid_m, din_valid_l, bit_en;
  logic         rdy_m, so_m, sv_m, wd_m, busy_m, st_m;
  logic         rdy_l, so_l, sv_l, wd_l, busy_l, st_l;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid_m), .din_ready(rdy_m),
    .bit_en(bit_en), .ser_out(so_m), .ser_valid(sv_m), .word_done(wd_m),
    .busy(busy_m), .state_dbg(st_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid_l), .din_ready(rdy_l),
    .bit_en(bit_en), .ser_out(so_l), .ser_valid(sv_l), .word_done(wd_l),
    .busy(busy_l), .state_dbg(st_l)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Driver state and per-cycle log of the selected DUT
  bit           use_lsb;
  int           en_mode;
  bit           gap_mode;
  bit           presenting;
  bit           pend_pop;
  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic log_sv[$], log_so[$], log_wd[$], log_busy[$], log_rdy[$], log_xfer[$], log_en[$];

  task automatic start_test(input bit lsb, input int mode, input bit gaps);
    use_lsb = lsb; en_mode = mode; gap_mode = gaps;
    presenting = 1'b0; pend_pop = 1'b0;
    src_q.delete(); exp_q.delete();
    log_sv.delete(); log_so.delete(); log_wd.delete(); log_busy.delete();
    log_rdy.delete(); log_xfer.delete(); log_en.delete();
    din_valid_m = 1'b0; din_valid_l = 1'b0; bit_en = 1'b0;
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next inputs.
  // A word presented while din_ready is high transfers on the coming rising edge.
  task automatic tick();
    logic rd, valid, xfer;
    @(negedge clk);
    log_sv.push_back(use_lsb ? sv_l : sv_m);
    log_so.push_back(use_lsb ? so_l : so_m);
    log_wd.push_back(use_lsb ? wd_l : wd_m);
    log_busy.push_back(use_lsb ? busy_l : busy_m);
    rd = use_lsb ? rdy_l : rdy_m;
    log_rdy.push_back(rd);
    if (pend_pop) begin
      void'(src_q.pop_front());
      pend_pop = 1'b0;
    end
    valid = 1'b0;
    if (src_q.size() > 0 && (!gap_mode || presenting || $urandom_range(0, 2) == 0)) valid = 1'b1;
    presenting = valid;
    if (valid) din = src_q[0];
    else din = W'($urandom);
    xfer = valid && rd;
    if (xfer) begin
      exp_q.push_back(src_q[0]);
      pend_pop = 1'b1;
    end
    log_xfer.push_back(xfer);
    case (en_mode)
      0:       bit_en = 1'b1;
      1:       bit_en = ~bit_en;
      default: bit_en = ($urandom_range(0, 3) != 0);
    endcase
    log_en.push_back(bit_en);
    din_valid_m = valid && !use_lsb;
    din_valid_l = valid && use_lsb;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int nth_xfer(input int n);
    int seen = 0;
    for (int c = 0; c < log_xfer.size(); c++) begin
      if (log_xfer[c] === 1'b1) begin
        if (seen == n) return c;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0; din_valid_m = 1'b0; din_valid_l = 1'b0; bit_en = 1'b1; din = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({so_m, sv_m, wd_m, busy_m, rdy_m, so_l, sv_l, wd_l, busy_l, rdy_l} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000000000",
               {so_m, sv_m, wd_m, busy_m, rdy_m, so_l, sv_l, wd_l, busy_l, rdy_l});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (rdy_m !== 1'b1 || rdy_l !== 1'b1 || busy_m !== 1'b0 || sv_m !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b/%b busy=%b sv=%b want 1/1 0 0", rdy_m, rdy_l, busy_m, sv_m);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w = 8'hB0;
    int x, c;
    logic e_sv, e_wd, e_busy, e_rdy;
    start_test(1'b0, 0, 1'b0);
    src_q.push_back(w);
    run(16);
    x = nth_xfer(0);
    vectors++;
    if (x < 0 || x + 13 > log_sv.size()) begin
      miscompares++;
      $display("FAIL single_xfer: transfer cycle %0d not usable", x);
      return;
    end
    for (int i = 0; i < 12; i++) begin
      c = x + 1 + i;
      e_sv = (i >= 2 && i <= 9); e_wd = (i == 9); e_busy = (i <= 8); e_rdy = (i >= 1);
      vectors++;
      if (log_sv[c] !== e_sv || log_wd[c] !== e_wd || log_busy[c] !== e_busy || log_rdy[c] !== e_rdy) begin
        miscompares++;
        $display("FAIL single_ctrl[%0d]: sv/wd/busy/rdy=%b%b%b%b want %b%b%b%b", i,
                 log_sv[c], log_wd[c], log_busy[c], log_rdy[c], e_sv, e_wd, e_busy, e_rdy);
      end
      if (e_sv) begin
        vectors++;
        if (log_so[c] !== w[W-1-(i-2)]) begin
          miscompares++;
          $display("FAIL single_bit[%0d]: got %b want %b", i - 2, log_so[c], w[W-1-(i-2)]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] s = 16'hA53C;
    int x, wd_cnt;
    start_test(1'b0, 0, 1'b0);
    src_q.push_back(8'hA5);
    src_q.push_back(8'h3C);
    run(26);
    x = nth_xfer(0);
    vectors++;
    if (x < 0 || x + 20 > log_sv.size()) begin
      miscompares++;
      $display("FAIL b2b_xfer: transfer cycle %0d not usable", x);
      return;
    end
    for (int i = 0; i < 2 * W; i++) begin
      vectors++;
      if (log_sv[x+3+i] !== 1'b1 || log_so[x+3+i] !== s[2*W-1-i] || log_wd[x+3+i] !== (i == W - 1 || i == 2 * W - 1)) begin
        miscompares++;
        $display("FAIL b2b_bit[%0d]: sv=%b so=%b wd=%b want 1 %b %b", i, log_sv[x+3+i],
                 log_so[x+3+i], log_wd[x+3+i], s[2*W-1-i], (i == W - 1 || i == 2 * W - 1));
      end
    end
    wd_cnt = 0;
    foreach (log_wd[c]) if (log_wd[c] === 1'b1) wd_cnt++;
    vectors++;
    if (wd_cnt != 2) begin
      miscompares++;
      $display("FAIL b2b_word_done_count: got %0d want 2", wd_cnt);
    end
  endtask

  task automatic test_three_words();
    logic [W-1:0] w[3];
    int x1, x2, x3, wd_cnt;
    start_test(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      w[i] = W'($urandom);
      src_q.push_back(w[i]);
    end
    run(36);
    x1 = nth_xfer(0); x2 = nth_xfer(1); x3 = nth_xfer(2);
    vectors++;
    if (x1 < 0 || x2 - x1 != 2 || x3 - x1 != W + 2 || nth_xfer(3) != -1) begin
      miscompares++;
      $display("FAIL three_xfer_cycles: got %0d %0d %0d want x, x+2, x+%0d", x1, x2, x3, W + 2);
      return;
    end
    for (int c = x2 + 1; c < x3; c++) begin
      vectors++;
      if (log_rdy[c] !== 1'b0) begin
        miscompares++;
        $display("FAIL three_ready_low[%0d]: got %b want 0", c - x1, log_rdy[c]);
      end
    end
    for (int i = 0; i < 3 * W; i++) begin
      vectors++;
      if (log_sv[x1+3+i] !== 1'b1 || log_so[x1+3+i] !== w[i/W][W-1-(i%W)]) begin
        miscompares++;
        $display("FAIL three_bit[%0d]: sv=%b so=%b want 1 %b", i, log_sv[x1+3+i],
                 log_so[x1+3+i], w[i/W][W-1-(i%W)]);
      end
    end
    wd_cnt = 0;
    foreach (log_wd[c]) if (log_wd[c] === 1'b1) wd_cnt++;
    vectors++;
    if (wd_cnt != 3) begin
      miscompares++;
      $display("FAIL three_word_done_count: got %0d want 3", wd_cnt);
    end
  endtask

  task automatic test_bit_en_toggle();
    logic [W-1:0] w = 8'hC3;
    int s[$];
    start_test(1'b0, 1, 1'b0);
    src_q.push_back(w);
    run(30);
    foreach (log_sv[c]) if (log_sv[c] === 1'b1) s.push_back(c);
    vectors++;
    if (s.size() != W) begin
      miscompares++;
      $display("FAIL toggle_strobe_count: got %0d want %0d", s.size(), W);
      return;
    end
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (log_so[s[i]] !== w[W-1-i] || log_wd[s[i]] !== (i == W - 1)) begin
        miscompares++;
        $display("FAIL toggle_bit[%0d]: so=%b wd=%b want %b %b", i, log_so[s[i]], log_wd[s[i]],
                 w[W-1-i], (i == W - 1));
      end
      if (i > 0) begin
        vectors++;
        if (s[i] - s[i-1] != 2 || log_so[s[i-1]+1] !== log_so[s[i-1]] || log_wd[s[i-1]+1] !== 1'b0) begin
          miscompares++;
          $display("FAIL toggle_gap[%0d]: spacing %0d so_between=%b want 2 %b", i,
                   s[i] - s[i-1], log_so[s[i-1]+1], log_so[s[i-1]]);
        end
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] w = 8'h81;
    int nstrobe, x, k, wd_cnt;
    start_test(1'b0, 0, 1'b0);
    src_q.push_back(8'hFF);
    nstrobe = 0;
    for (int i = 0; i < 20 && nstrobe < 3; i++) begin
      tick();
      if (log_sv[log_sv.size()-1] === 1'b1) nstrobe++;
    end
    vectors++;
    if (nstrobe != 3) begin
      miscompares++;
      $display("FAIL rst_mid_progress: got %0d strobes want 3", nstrobe);
    end
    #1 rst = 1'b0;
    #1;
    vectors++;
    if ({so_m, sv_m, wd_m, busy_m, rdy_m} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_mid_immediate: so/sv/wd/busy/rdy=%b want 00000", {so_m, sv_m, wd_m, busy_m, rdy_m});
    end
    @(negedge clk);
    vectors++;
    if ({so_m, sv_m, wd_m, busy_m, rdy_m} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_mid_held: so/sv/wd/busy/rdy=%b want 00000", {so_m, sv_m, wd_m, busy_m, rdy_m});
    end
    rst = 1'b1;
    start_test(1'b0, 0, 1'b0);
    src_q.push_back(w);
    run(16);
    x = nth_xfer(0);
    k = 0; wd_cnt = 0;
    for (int c = 0; c < log_sv.size(); c++) begin
      if (log_wd[c] === 1'b1) wd_cnt++;
      if (log_sv[c] === 1'b1) begin
        vectors++;
        if (k >= W || log_so[c] !== w[W-1-k] || c != x + 3 + k) begin
          miscompares++;
          $display("FAIL rst_after_bit[%0d]: so=%b cycle=%0d want %b at %0d", k, log_so[c], c,
                   (k < W) ? w[W-1-k] : 1'b0, x + 3 + k);
        end
        k++;
      end
    end
    vectors++;
    if (k != W || wd_cnt != 1) begin
      miscompares++;
      $display("FAIL rst_after_counts: bits=%0d word_done=%0d want %0d 1", k, wd_cnt, W);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] exp_seq = 8'b1011_0000;
    int k;
    start_test(1'b1, 0, 1'b0);
    src_q.push_back(8'h0D);
    run(16);
    k = 0;
    for (int c = 0; c < log_sv.size(); c++) begin
      if (log_sv[c] === 1'b1) begin
        vectors++;
        if (k >= W || log_so[c] !== exp_seq[W-1-k]) begin
          miscompares++;
          $display("FAIL lsb_bit[%0d]: got %b want %b", k, log_so[c], (k < W) ? exp_seq[W-1-k] : 1'b0);
        end
        k++;
      end
    end
    vectors++;
    if (k != W || busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL lsb_count: bits=%0d msb_busy=%b want %0d 0", k, busy_m, W);
    end
  endtask

  // Scoreboard: every transferred word must come out whole, in order, with
  // word_done on its last bit and each strobe preceded by an enabled cycle.
  task automatic test_random(input bit lsb);
    logic [W-1:0] cur;
    logic         e_bit;
    bit           have;
    int           k;
    start_test(lsb, 2, 1'b1);
    for (int i = 0; i < 12; i++) src_q.push_back(W'($urandom));
    run(320);
    have = 1'b0; k = 0; cur = '0;
    for (int c = 0; c < log_sv.size(); c++) begin
      if (log_sv[c] === 1'b1) begin
        if (!have && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have = 1'b1;
          k = 0;
        end
        vectors++;
        if (!have) begin
          miscompares++;
          $display("FAIL rand_extra_strobe[%0d]: strobe with no word outstanding", c);
        end else begin
          e_bit = lsb ? cur[k] : cur[W-1-k];
          if (log_so[c] !== e_bit || log_wd[c] !== (k == W - 1) || c == 0 || log_en[c-1] !== 1'b1) begin
            miscompares++;
            $display("FAIL rand_bit[c%0d k%0d]: so=%b wd=%b en_prev=%b want %b %b 1", c, k, log_so[c],
                     log_wd[c], (c > 0) ? log_en[c-1] : 1'b0, e_bit, (k == W - 1));
          end
          k++;
          if (k == W) have = 1'b0;
        end
      end else if (log_wd[c] === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL rand_word_done_alone[%0d]: word_done=1 want 0", c);
      end
    end
    vectors++;
    if (have || exp_q.size() != 0 || src_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: partial=%0d words_left=%0d unsent=%0d want 0 0 0", have, exp_q.size(), src_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_three_words();
    test_bit_en_toggle();
    test_reset_midword();
    test_lsb_first();
    test_random(1'b0);
    test_random(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
